// File: rtl/pc_pkg.sv
// Shared state encoding and default constants for the program-counter generator.
package pc_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } pc_state_e;

  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam int          DEF_INST_BYTES   = 4;
  localparam int          DEF_IALIGN_BITS  = 2;
  localparam int          DEF_RAS_DEPTH    = 4;

endpackage

// File: rtl/pc_gen_if.sv
// Fetch-side bundle of the PC generator: imem request, redirect/trap/halt controls and RAS hooks.
interface pc_gen_if #(
  parameter int XLEN = 32
);

  logic            is_stay;
  logic            fetch_ready;
  logic            fetch_req;
  logic [XLEN-1:0] pc;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_target;
  logic            trap_valid;
  logic [XLEN-1:0] trap_vector;
  logic            halt_req;
  logic            fetch_flush;
  logic            misalign_err;
  logic            ras_push;
  logic [XLEN-1:0] ras_push_addr;
  logic            ras_pop;
  logic            ras_empty;

  modport master (
    input  is_stay, fetch_ready, redirect_valid, redirect_target,
           trap_valid, trap_vector, halt_req, ras_push, ras_push_addr, ras_pop,
    output fetch_req, pc, fetch_flush, misalign_err, ras_empty
  );

  modport slave (
    output is_stay, fetch_ready, redirect_valid, redirect_target,
           trap_valid, trap_vector, halt_req, ras_push, ras_push_addr, ras_pop,
    input  fetch_req, pc, fetch_flush, misalign_err, ras_empty
  );

endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack; a push into a full stack overwrites the oldest entry.
module pc_ras #(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic [XLEN-1:0] push_addr,
  input  logic            pop,
  output logic [XLEN-1:0] top,
  output logic            empty,
  output logic            full
);

  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  logic [XLEN-1:0]  r_mem [RAS_DEPTH];
  logic [PTR_W-1:0] r_ptr;
  logic [CNT_W-1:0] r_cnt;
  logic [PTR_W-1:0] w_top_idx;
  logic             w_pop_ok;

  assign w_top_idx = r_ptr - PTR_W'(1);
  assign w_pop_ok  = pop && (r_cnt != '0);
  assign top       = r_mem[w_top_idx];
  assign empty     = (r_cnt == '0);
  assign full      = (r_cnt == CNT_W'(RAS_DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
      r_cnt <= '0;
    end else begin
      case ({push, w_pop_ok})
        2'b10: begin
          r_ptr <= r_ptr + PTR_W'(1);
          if (!full) r_cnt <= r_cnt + CNT_W'(1);
        end
        2'b01: begin
          r_ptr <= w_top_idx;
          r_cnt <= r_cnt - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Push alongside a pop replaces the entry just read, so depth stays put.
  always_ff @(posedge clk) begin
    if (push) r_mem[w_pop_ok ? w_top_idx : r_ptr] <= push_addr;
  end

endmodule

// File: rtl/pc_gen.sv
// IF-stage program-counter generator: boot/run/halt control, redirect/trap steering, fetch handshake.
// Optional return-address stack enabled with the PC_RAS_EN macro.
module pc_gen
  import pc_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEF_RESET_VECTOR),
  parameter int              INST_BYTES   = DEF_INST_BYTES,
  parameter int              IALIGN_BITS  = DEF_IALIGN_BITS,
  parameter int              RAS_DEPTH    = DEF_RAS_DEPTH
) (
  input logic      clk,
  input logic      resetn,
  pc_gen_if.master pc_if
);

  localparam logic [XLEN-1:0] LOW_MASK = XLEN'((64'd1 << IALIGN_BITS) - 64'd1);

  function automatic logic [XLEN-1:0] align_target(input logic [XLEN-1:0] addr);
    return addr & ~LOW_MASK;
  endfunction

  function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
    return |(addr & LOW_MASK);
  endfunction

  pc_state_e       r_state;
  logic [XLEN-1:0] r_pc;
  logic            r_fetch_req;
  logic            r_flush;
  logic            r_misalign;

  logic            w_steer;
  logic [XLEN-1:0] w_target;
  logic            w_advance;
  logic [XLEN-1:0] w_seq_pc;
  logic            w_ras_pop;
  logic [XLEN-1:0] w_ras_top;
  logic            w_ras_empty;

  assign w_steer   = pc_if.trap_valid || pc_if.redirect_valid;
  assign w_target  = pc_if.trap_valid ? pc_if.trap_vector : pc_if.redirect_target;
  assign w_seq_pc  = r_pc + XLEN'(INST_BYTES);
  assign w_advance = (r_state == ST_RUN) && !w_steer && !pc_if.halt_req &&
                     pc_if.fetch_ready && !pc_if.is_stay;

`ifdef PC_RAS_EN
  logic w_ras_full_unused;

  assign w_ras_pop = w_advance && pc_if.ras_pop;

  pc_ras #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst_n     (resetn),
    .push      (pc_if.ras_push),
    .push_addr (pc_if.ras_push_addr),
    .pop       (w_ras_pop),
    .top       (w_ras_top),
    .empty     (w_ras_empty),
    .full      (w_ras_full_unused)
  );
`else
  logic w_unused_ras;

  assign w_ras_pop    = 1'b0;
  assign w_ras_top    = '0;
  assign w_ras_empty  = 1'b1;
  assign w_unused_ras = ^{pc_if.ras_push, pc_if.ras_push_addr, pc_if.ras_pop, 1'(RAS_DEPTH)};
`endif

  // Trap and redirect override every state and ignore stall/ready; halt only freezes RUN.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= ST_BOOT;
      r_pc        <= RESET_VECTOR;
      r_fetch_req <= 1'b0;
      r_flush     <= 1'b0;
      r_misalign  <= 1'b0;
    end else begin
      r_flush    <= w_steer && r_fetch_req && !pc_if.fetch_ready;
      r_misalign <= w_steer && is_misaligned(w_target);
      if (w_steer) begin
        r_pc        <= align_target(w_target);
        r_state     <= ST_RUN;
        r_fetch_req <= 1'b1;
      end else begin
        case (r_state)
          ST_BOOT: begin
            r_state     <= ST_RUN;
            r_fetch_req <= 1'b1;
          end
          ST_RUN: begin
            if (pc_if.halt_req) begin
              r_state     <= ST_HALT;
              r_fetch_req <= 1'b0;
            end else if (w_advance) begin
              r_pc <= (w_ras_pop && !w_ras_empty) ? w_ras_top : w_seq_pc;
            end
          end
          ST_HALT: begin
            if (!pc_if.halt_req) begin
              r_state     <= ST_RUN;
              r_fetch_req <= 1'b1;
            end
          end
          default: begin
            r_state     <= ST_BOOT;
            r_fetch_req <= 1'b0;
          end
        endcase
      end
    end
  end

  assign pc_if.pc           = r_pc;
  assign pc_if.fetch_req    = r_fetch_req;
  assign pc_if.fetch_flush  = r_flush;
  assign pc_if.misalign_err = r_misalign;
  assign pc_if.ras_empty    = w_ras_empty;

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: directed scenarios plus random traffic against a queue-based reference model.
module tb_pc_gen;
  import pc_pkg::*;

  localparam int          XLEN = 32;
  localparam logic [31:0] RV   = 32'h0000_0000;
`ifdef PC_RAS_EN
  localparam bit RAS = 1'b1;
`else
  localparam bit RAS = 1'b0;
`endif
  localparam int M_BOOT = 0, M_RUN = 1, M_HALT = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic        req;
    logic        flush;
    logic        mis;
    logic        empty;
  } exp_t;

  typedef struct packed {
    logic        stay;
    logic        ready;
    logic        redir;
    logic [31:0] rtgt;
    logic        trap;
    logic [31:0] tvec;
    logic        halt;
    logic        push;
    logic [31:0] paddr;
    logic        pop;
  } stim_t;

  logic clk = 1'b0;
  logic resetn = 1'b1;
  always #5 clk = ~clk;

  pc_gen_if #(.XLEN(XLEN)) pc_if ();

  pc_gen #(
    .XLEN         (XLEN),
    .RESET_VECTOR (RV),
    .INST_BYTES   (4),
    .IALIGN_BITS  (2),
    .RAS_DEPTH    (4)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .pc_if  (pc_if)
  );

  exp_t        exp_q[$];
  int          checks   = 0;
  int          failures = 0;
  int          m_mode   = M_BOOT;
  logic [31:0] m_pc     = RV;
  logic [31:0] m_stack[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    s.ready = 1'b1;
    return s;
  endfunction

  function automatic exp_t model_view(input logic fl, input logic mi);
    exp_t e;
    e.pc    = m_pc;
    e.req   = (m_mode == M_RUN);
    e.flush = fl;
    e.mis   = mi;
    e.empty = RAS ? (m_stack.size() == 0) : 1'b1;
    return e;
  endfunction

  // One clock of stimulus; the model predicts what the DUT shows after the next rising edge.
  task automatic step(input stim_t s);
    logic        fl, mi, was_req;
    logic [31:0] tgt;
    @(negedge clk);
    resetn                = 1'b1;
    pc_if.is_stay         = s.stay;
    pc_if.fetch_ready     = s.ready;
    pc_if.redirect_valid  = s.redir;
    pc_if.redirect_target = s.rtgt;
    pc_if.trap_valid      = s.trap;
    pc_if.trap_vector     = s.tvec;
    pc_if.halt_req        = s.halt;
    pc_if.ras_push        = s.push;
    pc_if.ras_push_addr   = s.paddr;
    pc_if.ras_pop         = s.pop;
    fl = 1'b0;
    mi = 1'b0;
    was_req = (m_mode == M_RUN);
    if (s.trap || s.redir) begin
      tgt    = s.trap ? s.tvec : s.rtgt;
      fl     = was_req && !s.ready;
      mi     = (tgt % 4) != 0;
      m_pc   = (tgt / 4) * 4;
      m_mode = M_RUN;
    end else if (m_mode == M_BOOT) begin
      m_mode = M_RUN;
    end else if (m_mode == M_HALT) begin
      if (!s.halt) m_mode = M_RUN;
    end else if (s.halt) begin
      m_mode = M_HALT;
    end else if (s.ready && !s.stay) begin
      if (RAS && s.pop && m_stack.size() > 0) m_pc = m_stack.pop_back();
      else m_pc = m_pc + 32'd4;
    end
    if (RAS && s.push) begin
      if (m_stack.size() == 4) void'(m_stack.pop_front());
      m_stack.push_back(s.paddr);
    end
    exp_q.push_back(model_view(fl, mi));
  endtask

  task automatic apply_reset(input int cycles);
    @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("async_rst_pc", pc_if.pc, RV);
    chk("async_rst_req", 32'(pc_if.fetch_req), 32'd0);
    chk("async_rst_flush", 32'(pc_if.fetch_flush), 32'd0);
    chk("async_rst_mis", 32'(pc_if.misalign_err), 32'd0);
    chk("async_rst_empty", 32'(pc_if.ras_empty), 32'd1);
    m_pc   = RV;
    m_mode = M_BOOT;
    m_stack.delete();
    for (int i = 0; i < cycles; i++) begin
      exp_q.push_back(model_view(1'b0, 1'b0));
      @(posedge clk);
      #2;
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pc", pc_if.pc, e.pc);
        chk("fetch_req", 32'(pc_if.fetch_req), 32'(e.req));
        chk("fetch_flush", 32'(pc_if.fetch_flush), 32'(e.flush));
        chk("misalign_err", 32'(pc_if.misalign_err), 32'(e.mis));
        chk("ras_empty", 32'(pc_if.ras_empty), 32'(e.empty));
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    stim_t s;
    logic  halt_hold;
    {pc_if.is_stay, pc_if.redirect_valid, pc_if.trap_valid, pc_if.halt_req} = '0;
    {pc_if.ras_push, pc_if.ras_pop} = '0;
    pc_if.fetch_ready     = 1'b1;
    pc_if.redirect_target = '0;
    pc_if.trap_vector     = '0;
    pc_if.ras_push_addr   = '0;

    apply_reset(2);
    // Boot then sequential run up to 0x10.
    for (int i = 0; i < 5; i++) step(idle());
    s = idle(); s.stay = 1'b1;
    for (int i = 0; i < 3; i++) step(s);
    s = idle(); s.ready = 1'b0;
    for (int i = 0; i < 2; i++) step(s);
    step(idle());

    s = idle(); s.ready = 1'b0; s.redir = 1'b1; s.rtgt = 32'h200;
    step(s);
    s.trap = 1'b1; s.tvec = 32'h80;
    step(s);
    step(idle());
    s = idle(); s.redir = 1'b1; s.rtgt = 32'h103;
    step(s);
    step(idle());

    s = idle(); s.redir = 1'b1; s.rtgt = 32'h40;
    step(s);
    s = idle(); s.halt = 1'b1;
    for (int i = 0; i < 4; i++) step(s);
    s.redir = 1'b1; s.rtgt = 32'h300;
    step(s);
    step(idle());
    s = idle(); s.halt = 1'b1;
    for (int i = 0; i < 2; i++) step(s);
    step(idle());
    step(idle());

    s = idle(); s.redir = 1'b1; s.rtgt = 32'hFFFF_FFFC;
    step(s);
    step(idle());
    step(idle());
    s = idle(); s.stay = 1'b1; s.redir = 1'b1; s.rtgt = 32'h7F0;
    step(s);

    apply_reset(1);
    s = idle(); s.trap = 1'b1; s.tvec = 32'h502;
    step(s);
    step(idle());

    if (RAS) begin
      s = idle(); s.redir = 1'b1; s.rtgt = 32'h2000;
      step(s);
      for (int i = 0; i < 5; i++) begin
        s = idle(); s.ready = 1'b0; s.push = 1'b1; s.paddr = 32'h1004 + 32'(i) * 32'd4;
        step(s);
      end
      s = idle(); s.pop = 1'b1;
      for (int i = 0; i < 5; i++) step(s);
      s = idle(); s.push = 1'b1; s.pop = 1'b1; s.paddr = 32'h3000;
      step(s);
    end

    halt_hold = 1'b0;
    for (int n = 0; n < 600; n++) begin
      s = '0;
      s.ready = ($urandom_range(0, 3) != 0);
      s.stay  = ($urandom_range(0, 4) == 0);
      s.trap  = ($urandom_range(0, 39) == 0);
      s.redir = ($urandom_range(0, 11) == 0);
      s.tvec  = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & ~32'h3);
      s.rtgt  = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & ~32'h3);
      if ($urandom_range(0, 15) == 0) halt_hold = ~halt_hold;
      s.halt  = halt_hold;
      s.push  = ($urandom_range(0, 3) == 0);
      s.paddr = $urandom & ~32'h3;
      s.pop   = ($urandom_range(0, 3) == 0);
      step(s);
      if (n == 300) apply_reset(2);
    end

    apply_reset(2);
    for (int i = 0; i < 4; i++) step(idle());

    @(posedge clk);
    #3;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
